// File: rtl/usb_tx_if.sv
// usb_tx_if: request/grant and TX-engine signals shared by the USB TX scheduler and its clients
interface usb_tx_if;
    logic       hs_req;
    logic [1:0] hs_type;
    logic       data_req;
    logic       clear_toggle;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [2:0] tx_packet;
    logic       hs_grant;
    logic       data_grant;
    logic       pkt_done;
    logic       pkt_error;
    logic       busy;
    logic       data_toggle;
    modport master (
        output hs_req, hs_type, data_req, clear_toggle, tx_transfer_active, tx_error,
        input  tx_packet, hs_grant, data_grant, pkt_done, pkt_error, busy, data_toggle
    );
    modport slave (
        input  hs_req, hs_type, data_req, clear_toggle, tx_transfer_active, tx_error,
        output tx_packet, hs_grant, data_grant, pkt_done, pkt_error, busy, data_toggle
    );
endinterface

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates handshake/data requests and sequences one packet at a time through the TX engine
module usb_tx_scheduler (
    input logic   clk,
    input logic   n_rst,
    usb_tx_if.slave u
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, DONE, GAP} state_t;
    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [2:0] cmd, cmd_n;
    logic       fail, fail_n;
    logic       toggle, toggle_n;
    logic       is_hs;
    assign is_hs = cmd[2] | (cmd[1] & cmd[0]);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cmd_n   = cmd;
        fail_n  = fail;
        case (state)
            IDLE: begin
                if (u.hs_req) begin
                    state_n = ISSUE;
                    cmd_n   = u.hs_type == 2'd0 ? 3'd3 : u.hs_type == 2'd2 ? 3'd5 : 3'd4;
                    fail_n  = 1'b0;
                end else if (u.data_req) begin
                    state_n = ISSUE;
                    cmd_n   = toggle ? 3'd2 : 3'd1;
                    fail_n  = 1'b0;
                end
            end
            ISSUE: begin
                state_n = WAIT_START;
                cnt_n   = 5'd0;
            end
            WAIT_START: begin
                cnt_n = cnt + 5'd1;
                // an engine error or a start timeout both end the packet as a failure
                if (u.tx_error || (!u.tx_transfer_active && cnt == 5'd16)) begin
                    fail_n  = 1'b1;
                    state_n = DONE;
                end else if (u.tx_transfer_active) state_n = ACTIVE;
            end
            ACTIVE: begin
                fail_n = fail | u.tx_error;
                if (!u.tx_transfer_active) state_n = DONE;
            end
            DONE: begin
                state_n = GAP;
                cnt_n   = 5'd0;
            end
            GAP: begin
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd3) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign toggle_n = u.clear_toggle ? 1'b0 : (state == DONE && !fail && !is_hs) ? ~toggle : toggle;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            cmd    <= 3'd0;
            fail   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cmd    <= cmd_n;
            fail   <= fail_n;
            toggle <= toggle_n;
        end
    end
    // all outputs decode from registered state so reset clears them immediately
    assign u.tx_packet   = state == ISSUE ? cmd : 3'd0;
    assign u.hs_grant    = state == ISSUE && is_hs;
    assign u.data_grant  = state == ISSUE && !is_hs;
    assign u.pkt_done    = state == DONE && !fail;
    assign u.pkt_error   = state == DONE && fail;
    assign u.busy        = state != IDLE;
    assign u.data_toggle = toggle;
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: directed self-checking bench for usb_tx_scheduler
module tb_usb_tx_scheduler;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    usb_tx_if bus();
    usb_tx_scheduler dut (.clk(clk), .n_rst(n_rst), .u(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    // From IDLE: raise request(s), check ISSUE cycle, return in the first WAIT_START cycle
    task automatic request(input bit hs, input logic [1:0] ty, input bit dreq, input logic [2:0] pkt);
        bus.hs_req = hs;
        bus.hs_type = ty;
        bus.data_req = dreq;
        tick(1);
        chk("hs_grant", bus.hs_grant, hs);
        chk("data_grant", bus.data_grant, !hs);
        chk("tx_packet_issue", bus.tx_packet, pkt);
        chk("busy_issue", bus.busy, 1);
        bus.hs_req = 1'b0;
        if (!hs) bus.data_req = 1'b0;
        tick(1);
        chk("tx_packet_wait", bus.tx_packet, 0);
        chk("grant_cleared", bus.hs_grant | bus.data_grant, 0);
    endtask
    task automatic xfer_ok;
        bus.tx_transfer_active = 1'b1;
        tick(1);
        bus.tx_transfer_active = 1'b0;
        tick(1);
    endtask
    // Called in the DONE cycle; walks through GAP back to IDLE
    task automatic close_out(input bit done, input bit tog, input bit clr);
        chk("pkt_done", bus.pkt_done, done);
        chk("pkt_error", bus.pkt_error, !done);
        bus.clear_toggle = clr;
        tick(1);
        bus.clear_toggle = 1'b0;
        chk("pulse_end", bus.pkt_done | bus.pkt_error, 0);
        chk("data_toggle", bus.data_toggle, tog);
        tick(3);
        chk("busy_gap", bus.busy, 1);
        chk("no_grant_gap", bus.data_grant | bus.hs_grant, 0);
        tick(1);
        chk("busy_idle", bus.busy, 0);
    endtask
    initial begin
        bus.hs_req = 1'b1;
        bus.hs_type = 2'd0;
        bus.data_req = 1'b0;
        bus.clear_toggle = 1'b0;
        bus.tx_transfer_active = 1'b0;
        bus.tx_error = 1'b0;
        tick(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_packet", bus.tx_packet, 0);
        chk("rst_hs_grant", bus.hs_grant, 0);
        chk("rst_toggle", bus.data_toggle, 0);
        chk("rst_pulses", bus.pkt_done | bus.pkt_error, 0);
        bus.hs_req = 1'b0;
        n_rst = 1'b1;
        tick(3);
        chk("idle_no_req", bus.busy | bus.hs_grant | bus.data_grant, 0);
        // STALL and data together: handshake first, data granted 9 cycles later
        request(1'b1, 2'd2, 1'b1, 3'd5);
        xfer_ok();
        close_out(1'b1, 1'b0, 1'b0);
        request(1'b0, 2'd0, 1'b1, 3'd1);
        xfer_ok();
        close_out(1'b1, 1'b1, 1'b0);
        bus.clear_toggle = 1'b1;
        tick(1);
        bus.clear_toggle = 1'b0;
        chk("clear_idle", bus.data_toggle, 0);
        // Engine starts two cycles after ISSUE and stays busy for 20 cycles
        request(1'b0, 2'd0, 1'b1, 3'd1);
        tick(1);
        bus.tx_transfer_active = 1'b1;
        tick(1);
        chk("active_no_pkt", bus.tx_packet, 0);
        chk("active_no_done", bus.pkt_done, 0);
        tick(19);
        chk("active_late", bus.pkt_done | bus.pkt_error, 0);
        bus.tx_transfer_active = 1'b0;
        tick(1);
        close_out(1'b1, 1'b1, 1'b0);
        // Start timeout: error 17 cycles after WAIT_START entry
        request(1'b0, 2'd0, 1'b1, 3'd2);
        tick(16);
        chk("timeout_pending", bus.pkt_error, 0);
        chk("timeout_busy", bus.busy, 1);
        tick(1);
        close_out(1'b0, 1'b1, 1'b0);
        // Engine error pulse during ACTIVE is sticky
        request(1'b0, 2'd0, 1'b1, 3'd2);
        bus.tx_transfer_active = 1'b1;
        tick(1);
        bus.tx_error = 1'b1;
        tick(1);
        bus.tx_error = 1'b0;
        chk("err_active_stay", bus.busy, 1);
        chk("err_active_no_pulse", bus.pkt_error, 0);
        bus.tx_transfer_active = 1'b0;
        tick(1);
        close_out(1'b0, 1'b1, 1'b0);
        // Engine error in WAIT_START ends the packet immediately
        request(1'b0, 2'd0, 1'b1, 3'd2);
        bus.tx_error = 1'b1;
        tick(1);
        bus.tx_error = 1'b0;
        close_out(1'b0, 1'b1, 1'b0);
        request(1'b1, 2'd0, 1'b0, 3'd3);
        xfer_ok();
        close_out(1'b1, 1'b1, 1'b0);
        request(1'b1, 2'd3, 1'b0, 3'd4);
        xfer_ok();
        close_out(1'b1, 1'b1, 1'b0);
        // clear_toggle coincident with a successful data DONE
        request(1'b0, 2'd0, 1'b1, 3'd2);
        xfer_ok();
        close_out(1'b1, 1'b0, 1'b1);
        request(1'b0, 2'd0, 1'b1, 3'd1);
        xfer_ok();
        close_out(1'b1, 1'b0, 1'b1);
        request(1'b0, 2'd0, 1'b1, 3'd1);
        xfer_ok();
        close_out(1'b1, 1'b1, 1'b0);
        // Latched DATA1 command survives a toggle clear before ISSUE
        bus.clear_toggle = 1'b1;
        request(1'b0, 2'd0, 1'b1, 3'd2);
        bus.clear_toggle = 1'b0;
        chk("latched_toggle", bus.data_toggle, 0);
        xfer_ok();
        close_out(1'b1, 1'b1, 1'b0);
        // Asynchronous reset during ACTIVE
        request(1'b0, 2'd0, 1'b1, 3'd2);
        bus.tx_transfer_active = 1'b1;
        tick(1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_busy", bus.busy, 0);
        chk("async_toggle", bus.data_toggle, 0);
        chk("async_tx_packet", bus.tx_packet, 0);
        chk("async_pulses", bus.pkt_done | bus.pkt_error, 0);
        bus.tx_transfer_active = 1'b0;
        tick(1);
        n_rst = 1'b1;
        tick(1);
        chk("post_rst_pulses", bus.pkt_done | bus.pkt_error, 0);
        tick(3);
        chk("post_rst_idle", bus.busy | bus.pkt_done | bus.pkt_error, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
